// File: rtl/spi_lcd_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_lcd_rx
// Brief    : SPI (mode 0) LCD-bus receiver. Oversamples the SPI pins in the
//            system clock domain, assembles MSB-first bytes tagged with the
//            D/C flag and queues them in a small FIFO with valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module spi_lcd_rx #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    input  logic        spi_dc,
    input  logic        spi_cs,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_dc,
    output logic [15:0] frame_bytes,
    output logic        overflow,
    input  logic        ovf_clr,
    output logic        frame_err
);

    localparam logic [0:0]       c_st_idle  = 1'b0;
    localparam logic [0:0]       c_st_shift = 1'b1;
    localparam logic [FIFO_AW:0] c_depth    = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0] c_cnt_one  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] c_ptr_one = FIFO_AW'(1);

    // Synchronizer stages (third stage only on clock and chip select)
    logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic r_cs_s1, r_cs_s2, r_cs_s3;
    logic r_mosi_s1, r_mosi_s2;
    logic r_dc_s1, r_dc_s2;

    // Frame-start qualification after reset
    logic [1:0] r_fill;
    logic       r_cs_armed;

    // Byte assembly
    logic [0:0]  r_state;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_push;
    logic        r_push_dc;
    logic [15:0] r_frame_bytes;
    logic        r_frame_err;

    // FIFO
    logic [8:0]         r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow;

    logic       w_sclk_rise;
    logic       w_cs_fall;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_wr;
    logic       w_drop;
    logic [8:0] w_head;

    // Bring the SPI pins into the clk domain; CS idles high through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_cs_s3   <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_dc_s1   <= 1'b0;
            r_dc_s2   <= 1'b0;
        end else begin
            r_sclk_s1 <= spi_clk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_cs_s1   <= spi_cs;
            r_cs_s2   <= r_cs_s1;
            r_cs_s3   <= r_cs_s2;
            r_mosi_s1 <= spi_mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_dc_s1   <= spi_dc;
            r_dc_s2   <= r_dc_s1;
        end
    end

    // Arm frame detection only once a genuinely high CS has passed through
    // the synchronizer, so a CS held low across reset is not a new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill     <= 2'd0;
            r_cs_armed <= 1'b0;
        end else begin
            if (r_fill != 2'd3) begin
                r_fill <= r_fill + 2'd1;
            end
            if ((r_fill == 2'd3) && r_cs_s2) begin
                r_cs_armed <= 1'b1;
            end
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
    assign w_cs_fall   = r_cs_armed & r_cs_s3 & ~r_cs_s2;

    // Frame FSM: shift bits while CS is low, emit a push per completed byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'd0;
            r_push        <= 1'b0;
            r_push_dc     <= 1'b0;
            r_frame_bytes <= 16'd0;
            r_frame_err   <= 1'b0;
        end else begin
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_cs_fall) begin
                        r_state       <= c_st_shift;
                        r_bit_cnt     <= 3'd0;
                        r_frame_bytes <= 16'd0;
                    end
                end
                default: begin
                    if (r_cs_s2) begin
                        // A partial byte is simply abandoned
                        r_state   <= c_st_idle;
                        r_bit_cnt <= 3'd0;
                        if (r_bit_cnt != 3'd0) begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_sclk_rise) begin
                        r_shift   <= {r_shift[6:0], r_mosi_s2};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            // The full byte sits in r_shift during the push
                            // cycle; the next SPI edge is several clks away
                            r_push    <= 1'b1;
                            r_push_dc <= r_dc_s2;
                            if (r_frame_bytes != 16'hFFFF) begin
                                r_frame_bytes <= r_frame_bytes + 16'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);
    assign w_pop   = ~w_empty & rx_ready;
    // A full FIFO still accepts the push when the head leaves this cycle
    assign w_wr    = r_push & (~w_full | w_pop);
    assign w_drop  = r_push & w_full & ~w_pop;

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are qualified by the count, so no reset needed
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {r_push_dc, r_shift};
        end
    end

    // Sticky overflow; a new drop wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign w_head      = w_empty ? 9'd0 : r_mem[r_rd_ptr];
    assign rx_valid    = ~w_empty;
    assign rx_dc       = w_head[8];
    assign rx_data     = w_head[7:0];
    assign frame_bytes = r_frame_bytes;
    assign overflow    = r_overflow;
    assign frame_err   = r_frame_err;

endmodule
`default_nettype wire
